// File: rtl/tcb_net_rr_scheduler.sv
// Round-robin scheduler sharing one TCB classifier between N_REQ requesters.
// Grants, latches the image, starts the network, returns the tagged result.
module tcb_net_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int IMG_W   = 1152,
   parameter int PRED_W  = 32,
   parameter int TIMEOUT = 4096,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*IMG_W-1:0] req_img,
   output logic [N_REQ-1:0]       req_ready,
   output logic [IMG_W-1:0]       net_img,
   output logic                   net_valid,
   input  logic                   net_ready,
   input  logic [PRED_W-1:0]      net_number,
   output logic                   resp_valid,
   output logic [ID_W-1:0]        resp_id,
   output logic [PRED_W-1:0]      resp_number,
   output logic                   resp_err,
   output logic                   err_sticky,
   output logic                   busy,
   output logic [15:0]            infer_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     gnt_q, gnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [IMG_W-1:0]    img_q, img_d;
   logic [N_REQ-1:0]    req_ready_q, req_ready_d;
   logic                net_valid_q, net_valid_d;
   logic                resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]     resp_id_q, resp_id_d;
   logic [PRED_W-1:0]   resp_number_q, resp_number_d;
   logic                resp_err_q, resp_err_d;
   logic                err_sticky_q, err_sticky_d;
   logic                busy_q, busy_d;
   logic [15:0]         infer_cnt_q, infer_cnt_d;

   logic                found;
   logic [ID_W-1:0]     g_sel;

   // first requester at or after the pointer, wrapping around
   always_comb begin
      found = 1'b0;
      g_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_valid[(int'(ptr_q) + i) % N_REQ]) begin
            found = 1'b1;
            g_sel = ID_W'((int'(ptr_q) + i) % N_REQ);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      tmr_d         = tmr_q;
      img_d         = img_q;
      req_ready_d   = '0;
      net_valid_d   = 1'b0;
      resp_valid_d  = 1'b0;
      resp_id_d     = resp_id_q;
      resp_number_d = resp_number_q;
      resp_err_d    = resp_err_q;
      err_sticky_d  = err_sticky_q;
      infer_cnt_d   = infer_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d              = g_sel;
               img_d              = req_img[int'(g_sel)*IMG_W +: IMG_W];
               req_ready_d[g_sel] = 1'b1;
               state_d            = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            net_valid_d = 1'b1;
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            tmr_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (net_ready) begin
               resp_number_d = net_number;
               resp_err_d    = 1'b0;
               infer_cnt_d   = infer_cnt_q + 16'd1;
               resp_valid_d  = 1'b1;
               resp_id_d     = gnt_q;
               state_d       = S_RESP;
            end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
               resp_number_d = '0;
               resp_err_d    = 1'b1;
               err_sticky_d  = 1'b1;
               resp_valid_d  = 1'b1;
               resp_id_d     = gnt_q;
               state_d       = S_RESP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_RESP: begin
            if (int'(gnt_q) == N_REQ - 1) ptr_d = '0;
            else ptr_d = gnt_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         gnt_q         <= '0;
         tmr_q         <= '0;
         img_q         <= '0;
         req_ready_q   <= '0;
         net_valid_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_number_q <= '0;
         resp_err_q    <= 1'b0;
         err_sticky_q  <= 1'b0;
         busy_q        <= 1'b0;
         infer_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         tmr_q         <= tmr_d;
         img_q         <= img_d;
         req_ready_q   <= req_ready_d;
         net_valid_q   <= net_valid_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_number_q <= resp_number_d;
         resp_err_q    <= resp_err_d;
         err_sticky_q  <= err_sticky_d;
         busy_q        <= busy_d;
         infer_cnt_q   <= infer_cnt_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign net_img     = img_q;
   assign net_valid   = net_valid_q;
   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_number = resp_number_q;
   assign resp_err    = resp_err_q;
   assign err_sticky  = err_sticky_q;
   assign busy        = busy_q;
   assign infer_cnt   = infer_cnt_q;

endmodule

// File: tb/tb_tcb_net_rr_scheduler.sv
// Randomized bench for tcb_net_rr_scheduler against a job-level
// round-robin model (pointer, success count, sticky error).
module tb_tcb_net_rr_scheduler;

   localparam int N   = 4;
   localparam int IW  = 1152;
   localparam int PW  = 32;
   localparam int TO  = 16;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [IW-1:0]   imgs [N];
   logic [N*IW-1:0] req_img;
   logic [N-1:0]    req_ready;
   logic [IW-1:0]   net_img;
   logic            net_valid;
   logic            net_ready = 1'b0;
   logic [PW-1:0]   net_number = '0;
   logic            resp_valid;
   logic [IDW-1:0]  resp_id;
   logic [PW-1:0]   resp_number;
   logic            resp_err;
   logic            err_sticky;
   logic            busy;
   logic [15:0]     infer_cnt;

   assign req_img = {imgs[3], imgs[2], imgs[1], imgs[0]};

   always #5 clk = ~clk;

   tcb_net_rr_scheduler #(
      .N_REQ(N), .IMG_W(IW), .PRED_W(PW), .TIMEOUT(TO), .ID_W(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_img(req_img), .req_ready(req_ready),
      .net_img(net_img), .net_valid(net_valid),
      .net_ready(net_ready), .net_number(net_number),
      .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_number(resp_number), .resp_err(resp_err),
      .err_sticky(err_sticky), .busy(busy), .infer_cnt(infer_cnt)
   );

   int tests_run = 0;
   int failed    = 0;

   // job-level model state
   int m_ptr    = 0;
   int m_cnt    = 0;
   bit m_sticky = 0;

   // observed job results
   int            j_g;
   logic [N-1:0]  j_gv;
   bit            j_r1, j_nv, j_ok;
   logic [IW-1:0] j_img;
   int            j_wc;
   logic [1:0]    j_rid;
   logic [31:0]   j_rn;
   logic          j_re;

   function automatic logic [IW-1:0] rand_img();
      logic [IW-1:0] v;
      for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int model_grant(logic [N-1:0] rv);
      for (int i = 0; i < N; i++)
         if (rv[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   function automatic void model_done(int g, bit err);
      m_ptr = (g + 1) % N;
      if (err) m_sticky = 1;
      else m_cnt = (m_cnt + 1) % 65536;
   endfunction

   // drives one job; lat = WAIT cycle index of net_ready, <0 never
   task automatic do_job(input logic [N-1:0] rv, input int lat,
                         input logic [31:0] num, input bit hold);
      j_g = -1; j_gv = '0; j_r1 = 0; j_nv = 0; j_ok = 0;
      j_img = '0; j_wc = -1; j_rid = '0; j_rn = '0; j_re = 0;
      req_valid = rv;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (req_ready != 0) break;
      end
      j_gv = req_ready;
      if (j_gv == 0) begin
         req_valid = '0;
         return;
      end
      for (int i = 0; i < N; i++) if (j_gv[i]) j_g = i;
      @(negedge clk);
      j_r1  = (req_ready == 0);
      j_nv  = net_valid;
      j_img = net_img;
      if (!hold) req_valid = '0;
      @(negedge clk);
      for (int k = 0; k < TO + 8; k++) begin
         net_ready  = (k == lat);
         net_number = (k == lat) ? num : $urandom;
         @(negedge clk);
         net_ready = 1'b0;
         if (resp_valid) begin
            j_wc = k + 1; j_rid = resp_id; j_rn = resp_number;
            j_re = resp_err; j_ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, req_ready, net_valid, resp_valid, resp_err, err_sticky} !== '0) begin
         failed++;
         $display("FAIL reset_ctrl: got %b required 0",
                  {busy, req_ready, net_valid, resp_valid, resp_err, err_sticky});
      end
      tests_run++;
      if ({resp_id, resp_number} !== '0) begin
         failed++;
         $display("FAIL reset_resp: got id %0d num %0h required 0", resp_id, resp_number);
      end
      tests_run++;
      if (infer_cnt !== 16'd0) begin
         failed++;
         $display("FAIL reset_cnt: got %0d required 0", infer_cnt);
      end
      tests_run++;
      if (net_img !== '0) begin
         failed++;
         $display("FAIL reset_img: got %0h required 0", net_img[63:0]);
      end
   endtask

   task automatic test_single();
      int eg;
      imgs[2] = rand_img();
      eg = model_grant(4'b0100);
      do_job(4'b0100, 6, 32'd3, 0);
      model_done(eg, 0);
      tests_run++;
      if (j_gv !== 4'b0100 || !j_r1) begin
         failed++;
         $display("FAIL single_ready: got %b oneshot %0d required 0100 oneshot 1", j_gv, j_r1);
      end
      tests_run++;
      if (!j_nv || j_img !== imgs[2]) begin
         failed++;
         $display("FAIL single_issue: got nv %0d img %0h required nv 1 img %0h",
                  j_nv, j_img[63:0], imgs[2][63:0]);
      end
      tests_run++;
      if (!j_ok || j_wc !== 7) begin
         failed++;
         $display("FAIL single_latency: got ok %0d cyc %0d required 7", j_ok, j_wc);
      end
      tests_run++;
      if (j_rid !== 2'd2 || j_rn !== 32'd3 || j_re !== 1'b0) begin
         failed++;
         $display("FAIL single_resp: got id %0d num %0d err %0d required 2 3 0", j_rid, j_rn, j_re);
      end
      tests_run++;
      if (infer_cnt !== 16'(m_cnt)) begin
         failed++;
         $display("FAIL single_cnt: got %0d required %0d", infer_cnt, m_cnt);
      end
   endtask

   task automatic test_round_robin();
      int eg, lat;
      logic [31:0] num;
      for (int i = 0; i < N; i++) imgs[i] = rand_img();
      for (int j = 0; j < 8; j++) begin
         eg  = model_grant(4'b1111);
         lat = $urandom_range(0, 10);
         num = $urandom;
         do_job(4'b1111, lat, num, 1);
         model_done(eg, 0);
         tests_run++;
         if (!j_ok || j_g !== eg || int'(j_rid) !== eg) begin
            failed++;
            $display("FAIL rr_order[%0d]: got grant %0d id %0d required %0d", j, j_g, j_rid, eg);
         end
         tests_run++;
         if (j_img !== imgs[eg] || j_rn !== num || j_re !== 1'b0) begin
            failed++;
            $display("FAIL rr_data[%0d]: got num %0h err %0d required num %0h err 0",
                     j, j_rn, j_re, num);
         end
      end
      req_valid = '0;
      tests_run++;
      if (infer_cnt !== 16'(m_cnt)) begin
         failed++;
         $display("FAIL rr_cnt: got %0d required %0d", infer_cnt, m_cnt);
      end
   endtask

   task automatic test_pointer_skip();
      do_job(4'b0010, 2, 32'd11, 0);
      model_done(1, 0);
      tests_run++;
      if (j_g !== 1) begin
         failed++;
         $display("FAIL skip_first: got %0d required 1", j_g);
      end
      do_job(4'b1001, 3, 32'd12, 1);
      model_done(3, 0);
      tests_run++;
      if (j_g !== 3 || j_rid !== 2'd3) begin
         failed++;
         $display("FAIL skip_to3: got grant %0d id %0d required 3", j_g, j_rid);
      end
      do_job(4'b1001, 1, 32'd13, 0);
      model_done(0, 0);
      tests_run++;
      if (j_g !== 0 || j_rid !== 2'd0) begin
         failed++;
         $display("FAIL skip_to0: got grant %0d id %0d required 0", j_g, j_rid);
      end
   endtask

   task automatic test_timeout();
      int eg;
      logic [N-1:0] rv;
      rv = 4'($urandom_range(1, 15));
      eg = model_grant(rv);
      do_job(rv, -1, 32'd0, 0);
      model_done(eg, 1);
      tests_run++;
      if (!j_ok || j_wc !== TO) begin
         failed++;
         $display("FAIL timeout_cycles: got ok %0d cyc %0d required %0d", j_ok, j_wc, TO);
      end
      tests_run++;
      if (j_re !== 1'b1 || j_rn !== 32'd0 || int'(j_rid) !== eg) begin
         failed++;
         $display("FAIL timeout_resp: got err %0d num %0h id %0d required 1 0 %0d",
                  j_re, j_rn, j_rid, eg);
      end
      tests_run++;
      if (err_sticky !== 1'b1 || infer_cnt !== 16'(m_cnt)) begin
         failed++;
         $display("FAIL timeout_state: got sticky %0d cnt %0d required 1 %0d",
                  err_sticky, infer_cnt, m_cnt);
      end
      eg = model_grant(rv);
      do_job(rv, 4, 32'h55, 0);
      model_done(eg, 0);
      tests_run++;
      if (j_re !== 1'b0 || j_rn !== 32'h55 || err_sticky !== 1'b1) begin
         failed++;
         $display("FAIL timeout_after: got err %0d num %0h sticky %0d required 0 55 1",
                  j_re, j_rn, err_sticky);
      end
   endtask

   task automatic test_simultaneous();
      int eg;
      bit bad;
      bad = 0;
      req_valid = '0;
      net_ready = 1'b1;
      net_number = 32'hdead;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid || busy) bad = 1;
      end
      net_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid || busy) bad = 1;
      end
      tests_run++;
      if (bad) begin
         failed++;
         $display("FAIL stray_ready: got response or busy in idle, required none");
      end
      eg = model_grant(4'b0110);
      do_job(4'b0110, TO - 1, 32'h77, 0);
      model_done(eg, 0);
      tests_run++;
      if (!j_ok || j_wc !== TO || j_re !== 1'b0 || j_rn !== 32'h77) begin
         failed++;
         $display("FAIL edge_ready: got cyc %0d err %0d num %0h required %0d 0 77",
                  j_wc, j_re, j_rn, TO);
      end
   endtask

   task automatic test_random();
      int eg, lat, ew;
      bit err;
      logic [N-1:0] rv;
      logic [31:0] num;
      for (int j = 0; j < 24; j++) begin
         for (int i = 0; i < N; i++) imgs[i] = rand_img();
         rv  = 4'($urandom_range(1, 15));
         lat = $urandom_range(0, 20);
         num = $urandom;
         eg  = model_grant(rv);
         err = (lat > TO - 1);
         ew  = err ? TO : lat + 1;
         do_job(rv, lat, num, 0);
         model_done(eg, err);
         tests_run++;
         if (!j_ok || j_g !== eg || int'(j_rid) !== eg || j_img !== imgs[eg]) begin
            failed++;
            $display("FAIL rand_grant[%0d]: got grant %0d id %0d required %0d", j, j_g, j_rid, eg);
         end
         tests_run++;
         if (j_wc !== ew || j_re !== err || j_rn !== (err ? 32'd0 : num)) begin
            failed++;
            $display("FAIL rand_resp[%0d]: got cyc %0d err %0d num %0h required %0d %0d %0h",
                     j, j_wc, j_re, j_rn, ew, err, err ? 32'd0 : num);
         end
         tests_run++;
         if (infer_cnt !== 16'(m_cnt) || err_sticky !== m_sticky) begin
            failed++;
            $display("FAIL rand_state[%0d]: got cnt %0d sticky %0d required %0d %0d",
                     j, infer_cnt, err_sticky, m_cnt, m_sticky);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      do_job(4'b0001, 1, 32'd9, 0);
      model_done(0, 0);
      req_valid = 4'b0100;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         if (req_ready != 0) break;
      end
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL mid_busy: got %0d required 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({busy, req_ready, net_valid, resp_valid, resp_err, err_sticky} !== '0 ||
          {resp_id, resp_number} !== '0 || infer_cnt !== 16'd0 || net_img !== '0) begin
         failed++;
         $display("FAIL mid_reset: got busy %0d sticky %0d cnt %0d id %0d required all 0",
                  busy, err_sticky, infer_cnt, resp_id);
      end
      rst = 1'b0;
      m_ptr = 0; m_cnt = 0; m_sticky = 0;
      bad = 0;
      net_ready = 1'b1;
      net_number = 32'h1234;
      @(negedge clk);
      if (resp_valid) bad = 1;
      net_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) bad = 1;
      end
      tests_run++;
      if (bad) begin
         failed++;
         $display("FAIL mid_late_ready: got response after reset, required none");
      end
      do_job(4'b1111, 2, 32'd21, 0);
      model_done(0, 0);
      tests_run++;
      if (j_g !== 0 || j_rid !== 2'd0) begin
         failed++;
         $display("FAIL mid_ptr: got grant %0d required 0", j_g);
      end
      do_job(4'b0010, 5, 32'd22, 0);
      model_done(1, 0);
      tests_run++;
      if (!j_ok || j_rid !== 2'd1 || j_rn !== 32'd22 || j_re !== 1'b0 ||
          infer_cnt !== 16'(m_cnt)) begin
         failed++;
         $display("FAIL mid_after: got id %0d num %0d err %0d cnt %0d required 1 22 0 %0d",
                  j_rid, j_rn, j_re, infer_cnt, m_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) imgs[i] = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_pointer_skip();
      test_timeout();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/tcb_net_rr_scheduler.md
Name: tcb_net_rr_scheduler

Overview:
- Shares one TCB classifier instance (144-byte image in, 32-bit predicted class out, valid/ready handshake) between N_REQ image requesters.
- Arbitrates round-robin, latches the winner's image, and pulses the network's start.
- Waits for completion or timeout, then returns the prediction to the winner tagged with its requester ID.
- Sits between the image sources and the network top in the inference subsystem.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IMG_W, 1152, image width in bits (144 pixels x 8 bits).
- PRED_W, 32, prediction width in bits.
- TIMEOUT, 4096, maximum WAIT cycles before the in-flight job is aborted (>=2).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request
- req_img  in  N_REQ*IMG_W  images; requester i occupies bits [i*IMG_W +: IMG_W]
- req_ready  out  N_REQ  one-hot, 1-cycle accept pulse
- net_img  out  IMG_W  latched image driven to the network
- net_valid  out  1  1-cycle start pulse to the network
- net_ready  in  1  network completion
- net_number  in  PRED_W  network prediction; valid while net_ready=1
- resp_valid  out  1  1-cycle response pulse
- resp_id  out  ID_W  requester served
- resp_number  out  PRED_W  prediction; 0 on timeout
- resp_err  out  1  response was a timeout
- err_sticky  out  1  set on any timeout; cleared only by rst
- busy  out  1  high whenever state is not IDLE
- infer_cnt  out  16  count of successful responses; wraps at 65535 -> 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, round-robin pointer=0. All of the following reset to 0: req_ready, net_valid, resp_valid, resp_id, resp_number, resp_err, err_sticky, busy, infer_cnt, net_img, and the timer.
- Reset mid-operation: the in-flight job is abandoned with no response. A net_ready arriving later in IDLE is ignored.
- FSM states: IDLE, ACCEPT, ISSUE, WAIT, RESP. All outputs are registered and Moore-style:
  - req_ready[g]=1 only in ACCEPT.
  - net_valid=1 only in ISSUE.
  - resp_valid=1 only in RESP.
- IDLE: if any req_valid bit is set, grant g = the first set index scanning ptr, ptr+1, ... mod N_REQ. Latch g and its image into net_img, then go to ACCEPT. Otherwise stay in IDLE.
- ACCEPT (1 cycle): req_ready[g]=1, then go to ISSUE.
  - Requesters must hold req_valid and req_img stable until they sample req_ready.
  - req_valid changes during ACCEPT through RESP have no effect.
- ISSUE (1 cycle): net_valid=1, timer cleared, then go to WAIT. net_img stays stable from ACCEPT until the next grant.
- WAIT: sample net_ready every cycle.
  - net_ready=1: capture resp_number=net_number, set resp_err=0, increment infer_cnt, go to RESP.
  - Otherwise, if timer==TIMEOUT-1: set resp_number=0, resp_err=1, err_sticky=1, go to RESP.
  - Otherwise timer+1.
  - net_ready takes priority over timeout in the same cycle.
- RESP (1 cycle): resp_valid=1 with resp_id=g. Set ptr=(g+1) mod N_REQ, then go to IDLE.
- resp_id, resp_number and resp_err hold their values until the next RESP.
- net_ready outside WAIT is ignored.
- Latency: req_valid sampled at edge E0 -> req_ready high in cycle E0..E1 -> net_valid high in E1..E2. If net_ready is sampled at edge Ek, resp_valid is high in Ek..Ek+1.
- Throughput: a new grant can be sampled no earlier than the first edge after RESP, so there are at least 4 idle-overhead cycles per inference plus the network latency.
- Fairness: every continuously requesting requester is served within N_REQ grants.

Test Plan:
- Single request: after reset, req_valid=4'b0100 with a pattern image. Expect req_ready=4'b0100 for 1 cycle, net_valid 1 cycle later, net_img equal to the image, and model net_ready asserted 7 cycles later with net_number=3. Expect resp_valid, resp_id=2, resp_number=3, resp_err=0, infer_cnt=1.
- Round-robin: req_valid=4'b1111 held, 8 jobs. Expect grant order 0,1,2,3,0,1,2,3 and resp_id in the same order.
- Pointer skip: serve ID 1, then request only IDs 0 and 3. Expect ID 3 granted before ID 0.
- Timeout: TIMEOUT=16, net_ready never asserted. Expect resp_valid exactly 16 WAIT cycles after WAIT entry, resp_err=1, resp_number=0, err_sticky=1, infer_cnt unchanged. A following normal job returns resp_err=0 while err_sticky stays 1.
- Simultaneous events and stray ready: net_ready pulsed in IDLE is ignored (no resp_valid). net_ready coinciding with the timer reaching TIMEOUT-1 gives resp_err=0 with the captured net_number.
- Reset mid-job: assert rst during WAIT. Expect the next cycle busy=0, all outputs 0, ptr=0, and no resp_valid even if net_ready arrives afterwards. A new req_valid=4'b0010 is then served normally.
